car_cmd_responder: RTL and testbench



---
 rtl/car_cmd_responder_pkg.sv | 27 ++
 rtl/car_cmd_responder_det_sync.sv | 35 +++
 rtl/car_cmd_responder.sv | 146 ++++++++++++++
 tb/tb_car_cmd_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/car_cmd_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_cmd_responder_pkg                                                |
// | Shared constants and report FSM encoding for car_cmd_responder.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package car_cmd_responder_pkg;

  localparam logic [1:0] c_hdr = 2'b10;
  localparam logic [1:0] c_rsv = 2'b00;

  localparam int c_bit_straight = 0;
  localparam int c_bit_back     = 1;
  localparam int c_bit_left     = 2;
  localparam int c_bit_right    = 3;

  localparam int unsigned c_wdog_cycles_def  = 50_000_000;
  localparam int unsigned c_report_cycles_def = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } rpt_state_t;

endpackage
`default_nettype wire

// File: rtl/car_cmd_responder_det_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | det_sync                                                             |
// | Two-flop synchronizer for the 4 detector lines plus change detect.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module det_sync (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [3:0] det_raw,
  output logic [3:0] det_nib,
  output logic       det_changed
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;
  logic [3:0] r_prev;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 4'b0000;
      r_sync <= 4'b0000;
      r_prev <= 4'b0000;
    end else begin
      r_meta <= det_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign det_nib     = r_sync;
  assign det_changed = (r_sync != r_prev);

endmodule
`default_nettype wire

// File: rtl/car_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_cmd_responder                                                    |
// | UART command decoder with link watchdog and detector report FSM.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module car_cmd_responder
  import car_cmd_responder_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES   = c_wdog_cycles_def,
  parameter int unsigned REPORT_CYCLES = c_report_cycles_def
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       det_back,
  output logic       move_fwd,
  output logic       move_back,
  output logic       turn_left,
  output logic       turn_right,
  output logic       link_ok,
  output logic [7:0] err_count
);

  localparam int c_wd_w = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int c_rp_w = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [c_wd_w-1:0] c_wdog_max   = c_wd_w'(WDOG_CYCLES - 1);
  localparam logic [c_rp_w-1:0] c_period_max = c_rp_w'(REPORT_CYCLES - 1);

  logic              r_move_fwd, r_move_back, r_turn_left, r_turn_right;
  logic              r_link_ok;
  logic [7:0]        r_err_count;
  logic [c_wd_w-1:0] r_wdog;
  logic [c_rp_w-1:0] r_period;
  rpt_state_t        r_state;
  logic              r_pending;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;

  logic       w_accept, w_reject, w_expired;
  logic       w_period_hit, w_trig;
  logic [3:0] w_nib;
  logic       w_changed;

  assign w_accept  = rx_valid && (rx_data[7:6] == c_hdr) && (rx_data[5:4] == c_rsv);
  assign w_reject  = rx_valid && !w_accept;
  assign w_expired = (r_wdog == c_wdog_max);

  // An accepted frame takes priority over a coincident watchdog expiry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_move_fwd   <= 1'b0;
      r_move_back  <= 1'b0;
      r_turn_left  <= 1'b0;
      r_turn_right <= 1'b0;
      r_link_ok    <= 1'b0;
      r_err_count  <= 8'h00;
      r_wdog       <= '0;
    end else begin
      if (w_accept) begin
        r_wdog       <= '0;
        r_link_ok    <= 1'b1;
        r_move_fwd   <= rx_data[c_bit_straight] & ~rx_data[c_bit_back];
        r_move_back  <= rx_data[c_bit_back] & ~rx_data[c_bit_straight];
        r_turn_left  <= rx_data[c_bit_left] & ~rx_data[c_bit_right];
        r_turn_right <= rx_data[c_bit_right] & ~rx_data[c_bit_left];
      end else if (w_expired) begin
        r_link_ok    <= 1'b0;
        r_move_fwd   <= 1'b0;
        r_move_back  <= 1'b0;
        r_turn_left  <= 1'b0;
        r_turn_right <= 1'b0;
      end else begin
        r_wdog <= r_wdog + c_wd_w'(1);
      end
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  det_sync u_det_sync (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .det_raw     ({det_back, det_right, det_left, det_front}),
    .det_nib     (w_nib),
    .det_changed (w_changed)
  );

  assign w_period_hit = (r_period == c_period_max);
  assign w_trig       = w_period_hit || w_changed;

  // Triggers seen while a report is in flight collapse into one pending flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_period   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_period <= w_period_hit ? '0 : r_period + c_rp_w'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_trig || r_pending) begin
            r_state   <= ST_LOAD;
            r_pending <= 1'b0;
            r_period  <= '0;
          end
        end
        ST_LOAD: begin
          r_tx_data  <= {4'b0000, w_nib};
          r_tx_valid <= 1'b1;
          r_state    <= ST_WAIT;
          if (w_trig) r_pending <= 1'b1;
        end
        ST_WAIT: begin
          if (w_trig) r_pending <= 1'b1;
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move_fwd   = r_move_fwd;
  assign move_back  = r_move_back;
  assign turn_left  = r_turn_left;
  assign turn_right = r_turn_right;
  assign link_ok    = r_link_ok;
  assign err_count  = r_err_count;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_car_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_car_cmd_responder                                                 |
// | Directed bench with a behavioural reference model for the responder. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_car_cmd_responder;

  localparam int WD = 100;
  localparam int RC = 50;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic       det_front = 1'b0, det_left = 1'b0, det_right = 1'b0, det_back = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       move_fwd, move_back, turn_left, turn_right, link_ok;
  logic [7:0] err_count;

  car_cmd_responder #(.WDOG_CYCLES(WD), .REPORT_CYCLES(RC)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .det_front(det_front), .det_left(det_left), .det_right(det_right), .det_back(det_back),
    .move_fwd(move_fwd), .move_back(move_back), .turn_left(turn_left), .turn_right(turn_right),
    .link_ok(link_ok), .err_count(err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Motion as {fwd, back, left, right}; opposing requests cancel.
  function automatic logic [3:0] decode(input logic [3:0] f);
    return {f[0] & ~f[1], f[1] & ~f[0], f[2] & ~f[3], f[3] & ~f[2]};
  endfunction

  // ---------------- reference model ----------------
  int         m_now, m_last, m_err, m_since;
  bit         m_have, m_load, m_valid, m_owed;
  logic [3:0] m_frame, m_s1, m_sync, m_prev;
  logic [7:0] m_data;
  wire        m_idle = !m_load && !m_valid;
  wire        m_trig = (m_sync != m_prev) || (m_since == RC - 1);

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_now <= 0; m_last <= 0; m_err <= 0; m_since <= 0;
      m_have <= 0; m_load <= 0; m_valid <= 0; m_owed <= 0;
      m_frame <= 4'h0; m_s1 <= 4'h0; m_sync <= 4'h0; m_prev <= 4'h0;
      m_data <= 8'h00;
    end else begin
      m_now <= m_now + 1;
      if (rx_valid && rx_data[7:4] == 4'h8) begin
        m_have <= 1; m_last <= m_now + 1; m_frame <= rx_data[3:0];
      end else if (rx_valid && m_err < 255) begin
        m_err <= m_err + 1;
      end
      m_s1   <= {det_back, det_right, det_left, det_front};
      m_sync <= m_s1;
      m_prev <= m_sync;
      m_load <= m_idle && (m_trig || m_owed);
      if (m_idle && (m_trig || m_owed)) begin
        m_since <= 0; m_owed <= 0;
      end else begin
        m_since <= (m_since == RC - 1) ? 0 : m_since + 1;
        if (!m_idle && m_trig) m_owed <= 1;
      end
      if (m_load) begin
        m_valid <= 1; m_data <= {4'h0, m_sync};
      end else if (m_valid && tx_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n) begin
      bit live;
      live = m_have && (m_now - m_last < WD);
      check("motion", {move_fwd, move_back, turn_left, turn_right}, live ? decode(m_frame) : 4'h0);
      check("link_ok", link_ok, live);
      check("err_count", err_count, m_err);
      check("tx_valid", tx_valid, m_valid);
      if (m_valid) check("tx_data", tx_data, m_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (!tx_valid && n < limit) begin tick(1); n++; end
    check({name, "_timeout"}, tx_valid, 1'b1);
  endtask

  initial begin
    int cnt, i1, i2;
    logic [7:0] got [$];

    do_reset();
    check("rst_motion", {move_fwd, move_back, turn_left, turn_right}, 4'h0);
    check("rst_link", link_ok, 1'b0);
    check("rst_err", err_count, 8'h00);
    check("rst_txv", tx_valid, 1'b0);
    check("rst_txd", tx_data, 8'h00);

    send(8'h81);
    check("fwd_motion", {move_fwd, move_back, turn_left, turn_right}, 4'b1000);
    check("fwd_link", link_ok, 1'b1);
    send(8'h8A);
    check("back_right", {move_fwd, move_back, turn_left, turn_right}, 4'b0101);

    send(8'h43);
    send(8'h91);
    check("bad_hold", {move_fwd, move_back, turn_left, turn_right}, 4'b0101);
    check("bad_err2", err_count, 8'd2);

    send(8'h83);
    check("conf_sb", {move_fwd, move_back, turn_left, turn_right}, 4'b0000);
    send(8'h8C);
    check("conf_lr", {move_fwd, move_back, turn_left, turn_right}, 4'b0000);
    check("conf_err", err_count, 8'd2);

    // Frame landing on the watchdog expiry cycle wins.
    send(8'h81);
    tick(WD - 1);
    send(8'h82);
    check("wd_edge_link", link_ok, 1'b1);
    check("wd_edge_motion", {move_fwd, move_back, turn_left, turn_right}, 4'b0100);
    tick(WD);
    check("wd_exp_link", link_ok, 1'b0);
    check("wd_exp_motion", {move_fwd, move_back, turn_left, turn_right}, 4'b0000);

    for (int k = 0; k < 256; k++) send(8'h43);
    check("err_sat", err_count, 8'd255);

    // Quiet detectors after reset: no report before the first period.
    do_reset();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (tx_valid) cnt++;
      tick(1);
    end
    check("no_early_rpt", cnt, 0);

    tx_ready = 1'b0;
    det_left = 1'b1;
    wait_valid(10, "left_rpt");
    check("left_byte", tx_data, 8'h02);
    tick(3);
    check("wait_hold_v", tx_valid, 1'b1);
    check("wait_hold_d", tx_data, 8'h02);
    det_back = 1'b1;
    tick(5);
    check("wait_hold_d2", tx_data, 8'h02);
    tx_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid) got.push_back(tx_data);
      tick(1);
    end
    check("pend_count", got.size(), 2);
    if (got.size() == 2) begin
      check("pend_first", got[0], 8'h02);
      check("pend_second", got[1], 8'h0A);
    end

    // Periodic reports with static detectors.
    det_left = 1'b0; det_back = 1'b0;
    do_reset();
    i1 = -1; i2 = -1;
    for (int k = 0; k < 120; k++) begin
      if (tx_valid) begin
        if (i1 < 0) i1 = k; else if (i2 < 0) i2 = k;
      end
      tick(1);
    end
    check("period_first", i1, 51);
    check("period_gap", i2 - i1, RC);

    tx_ready = 1'b0;
    wait_valid(60, "mid_wait");
    rst_n = 1'b0;
    #1;
    check("rst_wait_txv", tx_valid, 1'b0);
    check("rst_wait_txd", tx_data, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
